// File: rtl/dmem_port_ctrl.sv
// Byte-serial data memory sequencer shared by the MEM stage and a loader.
// Words are big-endian: the lowest byte address holds bits 31:24.
module dmem_port_ctrl #(
    parameter int DEPTH = 40,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead_ex_mm,
    input  logic          MemWrite_ex_mm,
    input  logic [31:0]   address,
    input  logic [31:0]   foutput2_ex_mm,
    output logic          stall_mm,
    output logic [31:0]   data,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_ack,
    output logic [31:0]   ld_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Loader encodes as 0 so the all-zero reset leaves it as last owner.
    typedef enum logic {
        OWN_LD   = 1'b0,
        OWN_PIPE = 1'b1
    } owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_q, last_d;
    logic [1:0]    beat_q, beat_d;
    logic          we_q, we_d;
    logic          bad_q, bad_d;
    logic [AW-1:0] base_q, base_d;
    logic [31:0]   wword_q, wword_d;
    logic [31:0]   asm_q, asm_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   ldr_q, ldr_d;

    logic          pipe_req;
    logic          gnt_pipe;
    logic [31:0]   sel_addr;
    logic [32:0]   sel_end;
    logic [31:0]   result;

    assign pipe_req = MemRead_ex_mm | MemWrite_ex_mm;

    always_comb begin
        gnt_pipe = pipe_req & (~ld_req | (last_q == OWN_LD));
        sel_addr = gnt_pipe ? address : ld_addr;
        sel_end  = {1'b0, sel_addr} + 33'd3;
        result   = bad_q ? 32'd0 : asm_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        we_d    = we_q;
        bad_d   = bad_q;
        base_d  = base_q;
        wword_d = wword_q;
        asm_d   = asm_q;
        data_d  = data_q;
        ldr_d   = ldr_q;
        unique case (state_q)
            S_IDLE: begin
                if (pipe_req | ld_req) begin
                    owner_d = gnt_pipe ? OWN_PIPE : OWN_LD;
                    last_d  = gnt_pipe ? OWN_PIPE : OWN_LD;
                    we_d    = gnt_pipe ? MemWrite_ex_mm : ld_we;
                    wword_d = gnt_pipe ? foutput2_ex_mm : ld_wdata;
                    bad_d   = sel_end >= 33'(DEPTH);
                    base_d  = sel_addr[AW-1:0];
                    beat_d  = 2'd0;
                    asm_d   = 32'd0;
                    state_d = (sel_end >= 33'(DEPTH)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Byte for the previous beat arrives one cycle late.
                if (!we_q && beat_q != 2'd0) begin
                    asm_d = {asm_q[23:0], mem_rdata};
                end
                if (beat_q == 2'd3) begin
                    state_d = we_q ? S_DONE : S_DRAIN;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            S_DRAIN: begin
                asm_d   = {asm_q[23:0], mem_rdata};
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!we_q) begin
                    if (owner_q == OWN_PIPE) begin
                        data_d = result;
                    end else begin
                        ldr_d = result;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_LD;
            last_q  <= OWN_LD;
            beat_q  <= 2'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            base_q  <= '0;
            wword_q <= 32'd0;
            asm_q   <= 32'd0;
            data_q  <= 32'd0;
            ldr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            base_q  <= base_d;
            wword_q <= wword_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            ldr_q   <= ldr_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        if (state_q == S_RUN) begin
            mem_addr = base_q + AW'(beat_q);
            mem_re   = ~we_q;
            mem_we   = we_q;
            if (we_q) begin
                unique case (beat_q)
                    2'd0: mem_wdata = wword_q[31:24];
                    2'd1: mem_wdata = wword_q[23:16];
                    2'd2: mem_wdata = wword_q[15:8];
                    2'd3: mem_wdata = wword_q[7:0];
                    default: mem_wdata = 8'd0;
                endcase
            end
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign stall_mm = reset & pipe_req
                    & ~(state_q == S_DONE && owner_q == OWN_PIPE);
    assign err      = (state_q == S_DONE) & bad_q;
    assign ld_ack   = (state_q == S_DONE) & (owner_q == OWN_LD);
    assign data     = data_q;
    assign ld_rdata = ldr_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Scoreboard bench for dmem_port_ctrl with a behavioural byte memory.
// Expected beats and completions are queued; a negedge monitor checks them.
module tb_dmem_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_ex_mm, MemWrite_ex_mm;
    logic [31:0] address, foutput2_ex_mm;
    logic        stall_mm;
    logic [31:0] data;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_ack;
    logic [31:0] ld_rdata;
    logic [5:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        err;

    dmem_port_ctrl #(.DEPTH(40), .AW(6)) dut (
        .clk(clk), .reset(reset),
        .MemRead_ex_mm(MemRead_ex_mm), .MemWrite_ex_mm(MemWrite_ex_mm),
        .address(address), .foutput2_ex_mm(foutput2_ex_mm),
        .stall_mm(stall_mm), .data(data),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:63];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        bit         we;
        logic [5:0] addr;
        logic [7:0] wd;
    } beat_t;

    typedef struct {
        bit          is_ld;
        bit          we;
        bit          err;
        logic [31:0] rd;
    } comp_t;

    beat_t bq[$];
    comp_t cq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_beat(input bit we, input int a, input logic [7:0] wd);
        beat_t b;
        b.we = we;
        b.addr = 6'(a);
        b.wd = we ? wd : 8'd0;
        bq.push_back(b);
    endtask

    task automatic exp_x(input bit is_ld, input bit we, input int a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input bit bad);
        comp_t c;
        logic [31:0] w;
        w = wd;
        if (!bad) begin
            for (int k = 0; k < 4; k++) begin
                push_beat(we, a + k, w[31:24]);
                w = w << 8;
            end
        end
        c.is_ld = is_ld;
        c.we = we;
        c.err = bad;
        c.rd = bad ? 32'd0 : rd;
        cq.push_back(c);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a beat or a completion.
    logic [31:0] exp_data, exp_ldr;
    bit          pend;

    always @(negedge clk) begin
        if (!reset) begin
            pend = 0;
            exp_data = 32'd0;
            exp_ldr = 32'd0;
        end else begin
            if (pend) begin
                chk("data", {32'd0, data}, {32'd0, exp_data});
                chk("ld_rdata", {32'd0, ld_rdata}, {32'd0, exp_ldr});
                pend = 0;
            end
            if (mem_re || mem_we) begin
                if (bq.size() == 0) begin
                    chk("beat_unexpected", 64'd1, 64'd0);
                end else begin
                    beat_t b;
                    b = bq.pop_front();
                    chk("beat_we", {63'd0, mem_we}, {63'd0, b.we});
                    chk("beat_addr", {58'd0, mem_addr}, {58'd0, b.addr});
                    if (b.we) chk("beat_wdata", {56'd0, mem_wdata}, {56'd0, b.wd});
                end
            end
            if (ld_ack || err || ((MemRead_ex_mm || MemWrite_ex_mm) && !stall_mm)) begin
                if (cq.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    comp_t c;
                    c = cq.pop_front();
                    chk("done_ack", {63'd0, ld_ack}, {63'd0, c.is_ld});
                    chk("done_err", {63'd0, err}, {63'd0, c.err});
                    if (!c.we) begin
                        if (c.is_ld) exp_ldr = c.rd;
                        else exp_data = c.rd;
                    end
                    pend = 1;
                end
            end
        end
    end

    // Holds the request until DONE; returns in the following IDLE cycle.
    task automatic pipe_op(input bit we, input int a, input logic [31:0] wd,
                           input int exp_stall);
        int cnt;
        bit done;
        cnt = 0;
        done = 0;
        MemRead_ex_mm = ~we;
        MemWrite_ex_mm = we;
        address = a;
        foutput2_ex_mm = wd;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stall_mm) cnt++;
            else done = 1;
        end
        if (!done) begin
            $display("FAIL pipe_timeout: got stall stuck, expected release");
            n_fail++;
        end
        chk("stall_cycles", 64'(cnt), 64'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_idle();
        MemRead_ex_mm = 1'b0;
        MemWrite_ex_mm = 1'b0;
    endtask

    task automatic ld_op(input bit we, input int a, input logic [31:0] wd);
        bit done;
        done = 0;
        ld_req = 1'b1;
        ld_we = we;
        ld_addr = a;
        ld_wdata = wd;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ld_ack) done = 1;
        end
        if (!done) begin
            $display("FAIL ld_timeout: got no ld_ack, expected one");
            n_fail++;
        end
        @(posedge clk);
        #1;
        ld_req = 1'b0;
    endtask

    task automatic chk_outs_zero(input string nm);
        chk(nm, {stall_mm, ld_ack, mem_re, mem_we, err, mem_addr, mem_wdata},
            64'd0);
        chk({nm, "_data"}, {data, ld_rdata}, 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        pipe_idle();
        address = 0;
        foutput2_ex_mm = 0;
        ld_req = 0;
        ld_we = 0;
        ld_addr = 0;
        ld_wdata = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(8'hA0 + i);
        mem[8] = 8'h00;
        mem[9] = 8'h00;
        mem[10] = 8'h19;
        mem[11] = 8'h00;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset_outs");
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Tie after reset: pipe first, then loader wins the re-request tie.
        exp_x(0, 0, 0, 0, 32'hA0A1A2A3, 0);
        exp_x(1, 1, 4, 32'h11223344, 0, 0);
        exp_x(0, 0, 8, 0, 32'h00001900, 0);
        fork
            begin
                pipe_op(0, 0, 0, 6);
                pipe_op(0, 8, 0, 12);
                pipe_idle();
            end
            ld_op(1, 4, 32'h11223344);
        join

        exp_x(1, 0, 4, 0, 32'h11223344, 0);
        ld_op(0, 4, 0);

        exp_x(0, 1, 12, 32'hDEADBEEF, 0, 0);
        pipe_op(1, 12, 32'hDEADBEEF, 5);
        pipe_idle();
        exp_x(0, 0, 12, 0, 32'hDEADBEEF, 0);
        pipe_op(0, 12, 0, 6);
        pipe_idle();

        exp_x(0, 0, 37, 0, 0, 1);
        pipe_op(0, 37, 0, 1);
        pipe_idle();

        exp_x(0, 0, 8, 0, 32'h00001900, 0);
        exp_x(0, 1, 20, 32'h01020304, 0, 0);
        pipe_op(0, 8, 0, 6);
        pipe_op(1, 20, 32'h01020304, 5);
        pipe_idle();
        repeat (2) @(negedge clk);
        chk("data_after_write", {32'd0, data}, 64'h00001900);

        // Reset lands mid-cycle in write beat 2.
        @(posedge clk);
        #1;
        push_beat(1, 16, 8'hAA);
        push_beat(1, 17, 8'hBB);
        push_beat(1, 18, 8'hCC);
        MemWrite_ex_mm = 1'b1;
        address = 16;
        foutput2_ex_mm = 32'hAABBCCDD;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_outs_zero("async_reset_outs");
        pipe_idle();
        repeat (2) @(negedge clk);
        chk_outs_zero("held_reset_outs");
        @(posedge clk);
        #3 reset = 1'b1;
        chk("mem16", {56'd0, mem[16]}, 64'hAA);
        chk("mem17", {56'd0, mem[17]}, 64'hBB);
        chk("mem18", {56'd0, mem[18]}, 64'hB2);
        chk("mem19", {56'd0, mem[19]}, 64'hB3);
        @(posedge clk);
        #1;

        exp_x(0, 0, 16, 0, 32'hAABBB2B3, 0);
        pipe_op(0, 16, 0, 6);
        exp_x(0, 0, 20, 0, 32'h01020304, 0);
        pipe_op(0, 20, 0, 6);
        pipe_idle();
        repeat (3) @(negedge clk);

        chk("beats_left", 64'(bq.size()), 64'd0);
        chk("dones_left", 64'(cq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
